miriscv_alu_arbiter: RTL and testbench
======================================

# miriscv_alu_arbiter

Shares one `miriscv_alu` instance between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit. Each requester uses a valid/ready request handshake and a valid/ready response handshake. Arbitration is round-robin, and the block accepts at most one operation per cycle. Each result is registered into a one-entry response slot owned by the requester that issued the operation.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `ALU_OP_WIDTH`, 7: opcode width, equal to the package ALU opcode width.

Ports (index 0 = execute, index 1 = branch unit):
- `clk_i` in 1: the only clock.
- `arstn_i` in 1: reset, asynchronous and active-low.
- `req_valid_i` in 2: request valid, per requester.
- `req_ready_o` out 2: request accepted this cycle, per requester.
- `req_op_i` in 2*ALU_OP_WIDTH: opcode; slice i belongs to requester i.
- `req_a_i` in 2*XLEN: operand A, sliced per requester.
- `req_b_i` in 2*XLEN: operand B, sliced per requester.
- `rsp_valid_o` out 2: response slot i holds a result.
- `rsp_ready_i` in 2: requester i consumes its response.
- `rsp_result_o` out 2*XLEN: registered `result_o`, sliced per requester.
- `rsp_cmp_o` out 2: registered `comparison_result_o`, per requester.
- `conflict_cnt_o` out 16: count of cycles in which both requesters were eligible.

## Operation
- Eligibility: requester i is eligible when `req_valid_i[i]` is high and (`!rsp_valid_o[i]` or `rsp_ready_i[i]`).
  - A slot that is drained in a cycle can be refilled in the same cycle.
- Grant, combinational, at most one requester:
  - If neither requester is eligible, there is no grant.
  - If exactly one is eligible, that requester is granted.
  - If both are eligible, the requester selected by `prio` is granted.
- `req_ready_o[i]` equals grant[i]. The request transfer happens when valid and ready are both high.
  - `req_ready_o` depends combinationally on `req_valid_i` and `rsp_ready_i`. Requesters must not make `req_valid_i` depend on `req_ready_o`.
- ALU inputs take the opcode and operands of the granted requester. With no grant they take requester 0's inputs; the ALU result is unused in that case.
- On every clock edge, slot i is updated as follows:
  - If grant[i]: `rsp_result_o[i]` and `rsp_cmp_o[i]` take the ALU outputs, and `rsp_valid_o[i]` is set to 1.
  - Else if `rsp_ready_i[i]` is high: `rsp_valid_o[i]` is set to 0. Data is held.
  - Otherwise the slot holds.
- `prio` update:
  - On any grant, `prio` takes the index of the requester that was not granted.
  - With no grant, `prio` holds.
- `conflict_cnt_o` increments when both requesters are eligible. It saturates at 16'hFFFF.
- Opcodes are passed to the ALU unchanged. The result for an undefined opcode is whatever the ALU produces; the arbiter does not check opcodes.
- No ordering is kept between the two ports. Within a single port, results are returned in issue order because the slot holds only one entry.

## Timing
- Reset, asynchronous, while `arstn_i` = 0:
  - `rsp_valid_o` = 2'b00, `rsp_result_o` = 0, `rsp_cmp_o` = 0.
  - `prio` = 0, `conflict_cnt_o` = 0.
  - `req_ready_o` = 2'b00, because `req_valid_i` is ignored while in reset.
- Reset asserted in the middle of a transfer drops all pending responses with no handshake.
- Latency: a request accepted at edge N has `rsp_valid_o` high in the cycle after edge N, which is one cycle of latency.
- Throughput:
  - One operation per cycle in total across both ports.
  - One operation per cycle per port when that port's `rsp_ready_i` is held high.
- Starvation: while both requesters stay eligible, grants alternate every cycle. A waiting eligible requester is granted within 2 cycles.
- Backpressure:
  - A full slot with `rsp_ready_i[i]` = 0 blocks requester i only. The other port continues unaffected.
  - A full slot holds its result and comparison bit stable until it is consumed.

## Structure
- Package `miriscv_pkg` contains:
  - The ALU opcode constants `ALU_ADD`, `ALU_SUB`, `ALU_XOR`, `ALU_OR`, `ALU_AND`, `ALU_SRA`, `ALU_SRL`, `ALU_SLL`, `ALU_LTS`, `ALU_LTU`, `ALU_GES`, `ALU_GEU`, `ALU_EQ`, `ALU_NE`.
  - `ALU_OP_WIDTH`.
  - The requester index constants `REQ_EXEC` = 0 and `REQ_BR` = 1.
- Sub-modules: one instance of the existing `miriscv_alu`. The grant logic stays inline and is not split into a separate sub-module.

## Test plan
- **Single issue:** port 0 issues `ALU_ADD` with a=5, b=7 and `rsp_ready_i` = 2'b11. Required: `rsp_valid_o[0]` rises one cycle later with result 12; `rsp_valid_o[1]` stays 0.
- **Simultaneous requests after reset:**
  - Stimulus: port 0 issues `ALU_SUB` with a=1, b=2; port 1 issues `ALU_LTS` with a=-1, b=1.
  - Required: port 0 is granted first and returns 32'hFFFFFFFF. Port 1 is granted the next cycle and returns result 1 with `rsp_cmp_o[1]` = 1. `conflict_cnt_o` = 1.
- **Sustained contention:** both ports are held valid for 10 cycles with `rsp_ready_i` = 2'b11. Required: grants alternate 0,1,0,1…, giving 5 grants per port, and `conflict_cnt_o` = 10.
- **Backpressure:**
  - Stimulus: `rsp_ready_i[0]` = 0; port 0 issues `ALU_XOR` with a=-1, b=1, then issues a second request.
  - Required: the first request returns 32'hFFFFFFFE. The second request gets no ready while port 1 (`ALU_SLL` with a=1, b=1, result 2) continues to be served. Raising `rsp_ready_i[0]` causes the second request to be accepted in that same cycle.
- **Reset mid-operation:** assert `arstn_i` = 0 asynchronously, between edges, while both slots are full. Required: `rsp_valid_o` goes to 0 immediately; after release the first grant goes to port 0.
- **Counter saturation:** force contention for 65540 cycles. Required: `conflict_cnt_o` stops at 16'hFFFF.

Source files
------------

// File: rtl/miriscv_pkg.sv
// miriscv_pkg: shared definitions for the ALU and the ALU arbiter.
//   - ALU opcode constants and their width
//   - requester index constants used to slice the per-requester buses
//   - alu_is_cmp(): true for opcodes that produce a comparison result
package miriscv_pkg;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 7'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 7'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 7'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 7'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA = 7'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 7'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 7'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS = 7'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU = 7'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES = 7'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU = 7'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ  = 7'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE  = 7'd13;

  localparam int REQ_EXEC = 0;
  localparam int REQ_BR   = 1;

  function automatic logic alu_is_cmp(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= ALU_LTS) && (op <= ALU_NE);
  endfunction

endpackage

// File: rtl/miriscv_alu_arbiter_if.sv
// miriscv_alu_arbiter_if: request/response bus between two requesters and
// the ALU arbiter. Index 0 = execute stage, index 1 = branch unit; the
// packed buses are sliced per requester.
//   master: requester side (drives requests, consumes responses)
//   slave : arbiter side
interface miriscv_alu_arbiter_if #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 7
);
  logic [1:0]                req_valid_i;
  logic [1:0]                req_ready_o;
  logic [2*ALU_OP_WIDTH-1:0] req_op_i;
  logic [2*XLEN-1:0]         req_a_i;
  logic [2*XLEN-1:0]         req_b_i;
  logic [1:0]                rsp_valid_o;
  logic [1:0]                rsp_ready_i;
  logic [2*XLEN-1:0]         rsp_result_o;
  logic [1:0]                rsp_cmp_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_cmp_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_cmp_o
  );
endinterface

// File: rtl/miriscv_alu.sv
// miriscv_alu: purely combinational integer ALU.
//   alu_op_i            opcode (miriscv_pkg ALU_*)
//   alu_a_i / alu_b_i   operands
//   result_o            arithmetic result, or the comparison bit zero-extended
//   comparison_result_o comparison outcome, 0 for non-compare opcodes
// Undefined opcodes yield zero on both outputs.
module miriscv_alu
  import miriscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [XLEN-1:0]         alu_a_i,
  input  logic [XLEN-1:0]         alu_b_i,
  output logic [XLEN-1:0]         result_o,
  output logic                    comparison_result_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  logic           lts_s;
  logic           ltu_s;
  logic           eq_s;
  logic           cmp_s;

  assign shamt_s = alu_b_i[SHW-1:0];
  assign lts_s   = $signed(alu_a_i) < $signed(alu_b_i);
  assign ltu_s   = alu_a_i < alu_b_i;
  assign eq_s    = alu_a_i == alu_b_i;

  // Comparison outcome for compare opcodes.
  always_comb begin
    cmp_s = 1'b0;
    case (alu_op_i)
      ALU_LTS: cmp_s = lts_s;
      ALU_LTU: cmp_s = ltu_s;
      ALU_GES: cmp_s = ~lts_s;
      ALU_GEU: cmp_s = ~ltu_s;
      ALU_EQ:  cmp_s = eq_s;
      ALU_NE:  cmp_s = ~eq_s;
      default: cmp_s = 1'b0;
    endcase
  end

  // Result selection; compare opcodes return the comparison bit.
  always_comb begin
    result_o            = {XLEN{1'b0}};
    comparison_result_o = 1'b0;
    if (alu_is_cmp(alu_op_i)) begin
      result_o            = {{(XLEN-1){1'b0}}, cmp_s};
      comparison_result_o = cmp_s;
    end else begin
      case (alu_op_i)
        ALU_ADD: result_o = alu_a_i + alu_b_i;
        ALU_SUB: result_o = alu_a_i - alu_b_i;
        ALU_XOR: result_o = alu_a_i ^ alu_b_i;
        ALU_OR:  result_o = alu_a_i | alu_b_i;
        ALU_AND: result_o = alu_a_i & alu_b_i;
        ALU_SRA: result_o = $unsigned($signed(alu_a_i) >>> shamt_s);
        ALU_SRL: result_o = alu_a_i >> shamt_s;
        ALU_SLL: result_o = alu_a_i << shamt_s;
        default: result_o = {XLEN{1'b0}};
      endcase
    end
  end
endmodule

// File: rtl/miriscv_alu_arbiter.sv
// miriscv_alu_arbiter: shares one miriscv_alu between the execute stage
// (requester 0) and the branch unit (requester 1).
//   clk_i, arstn_i  clock and asynchronous active-low reset
//   bus             request/response handshakes (slave side)
//   conflict_cnt_o  saturating count of cycles with both requesters eligible
// Round-robin grant, one operation per cycle, one registered response slot
// per requester. req_ready_o is combinational from req_valid_i/rsp_ready_i.
module miriscv_alu_arbiter #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = miriscv_pkg::ALU_OP_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  miriscv_alu_arbiter_if.slave  bus,
  output logic [15:0]           conflict_cnt_o
);
  import miriscv_pkg::*;

  logic [1:0]              elig_s;
  logic [1:0]              grant_s;
  logic [ALU_OP_WIDTH-1:0] alu_op_s;
  logic [XLEN-1:0]         alu_a_s;
  logic [XLEN-1:0]         alu_b_s;
  logic [XLEN-1:0]         alu_result_s;
  logic                    alu_cmp_s;

  logic                    prio_r;
  logic [1:0]              rsp_valid_r;
  logic [2*XLEN-1:0]       rsp_result_r;
  logic [1:0]              rsp_cmp_r;
  logic [15:0]             conflict_cnt_r;

  // Eligibility: a slot drained this cycle can be refilled; nothing is
  // eligible while reset is asserted.
  always_comb begin
    elig_s = bus.req_valid_i & (~rsp_valid_r | bus.rsp_ready_i) & {2{arstn_i}};
  end

  // Round-robin grant; prio_r names the requester that wins a tie.
  always_comb begin
    grant_s = 2'b00;
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = prio_r ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  // ALU operand mux; defaults to requester 0 when nobody is granted.
  always_comb begin
    alu_op_s = bus.req_op_i[ALU_OP_WIDTH-1:0];
    alu_a_s  = bus.req_a_i[XLEN-1:0];
    alu_b_s  = bus.req_b_i[XLEN-1:0];
    if (grant_s[REQ_BR]) begin
      alu_op_s = bus.req_op_i[2*ALU_OP_WIDTH-1:ALU_OP_WIDTH];
      alu_a_s  = bus.req_a_i[2*XLEN-1:XLEN];
      alu_b_s  = bus.req_b_i[2*XLEN-1:XLEN];
    end else begin
      alu_op_s = bus.req_op_i[ALU_OP_WIDTH-1:0];
      alu_a_s  = bus.req_a_i[XLEN-1:0];
      alu_b_s  = bus.req_b_i[XLEN-1:0];
    end
  end

  miriscv_alu #(.XLEN(XLEN)) u_alu (
    .alu_op_i            (alu_op_s),
    .alu_a_i             (alu_a_s),
    .alu_b_i             (alu_b_s),
    .result_o            (alu_result_s),
    .comparison_result_o (alu_cmp_s)
  );

  // Response slots, round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rsp_valid_r    <= 2'b00;
      rsp_result_r   <= {(2*XLEN){1'b0}};
      rsp_cmp_r      <= 2'b00;
      prio_r         <= 1'b0;
      conflict_cnt_r <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant_s[i]) begin
          rsp_valid_r[i]               <= 1'b1;
          rsp_result_r[i*XLEN +: XLEN] <= alu_result_s;
          rsp_cmp_r[i]                 <= alu_cmp_s;
        end else if (bus.rsp_ready_i[i]) begin
          rsp_valid_r[i] <= 1'b0;
        end
      end
      // Priority passes to the requester that lost (or did not ask).
      if (grant_s != 2'b00) begin
        prio_r <= grant_s[REQ_EXEC];
      end
      if ((elig_s == 2'b11) && (conflict_cnt_r != 16'hFFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end
    end
  end

  assign bus.req_ready_o  = grant_s;
  assign bus.rsp_valid_o  = rsp_valid_r;
  assign bus.rsp_result_o = rsp_result_r;
  assign bus.rsp_cmp_o    = rsp_cmp_r;
  assign conflict_cnt_o   = conflict_cnt_r;
endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// tb_miriscv_alu_arbiter: directed scenarios plus randomized traffic against
// a behavioural model of the arbitration rules; expected responses are queued
// per port and popped by an independent monitor on each response handshake.
module tb_miriscv_alu_arbiter;
  import miriscv_pkg::*;

  localparam int XLEN = 32;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic [15:0] conflict_cnt;

  miriscv_alu_arbiter_if #(.XLEN(XLEN), .ALU_OP_WIDTH(ALU_OP_WIDTH)) bus ();

  miriscv_alu_arbiter #(.XLEN(XLEN), .ALU_OP_WIDTH(ALU_OP_WIDTH)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .bus            (bus),
    .conflict_cnt_o (conflict_cnt)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  // Stimulus registers for the current cycle, per requester.
  logic [ALU_OP_WIDTH-1:0] op_v [2];
  logic [XLEN-1:0]         a_v  [2];
  logic [XLEN-1:0]         b_v  [2];
  logic [1:0]              last_ready;

  // Behavioural model state.
  logic [1:0] m_full;
  int         m_prio;
  int         m_cnt;
  logic [32:0] sb0 [$];
  logic [32:0] sb1 [$];

  logic [ALU_OP_WIDTH-1:0] op_tab [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: {comparison bit, result}.
  function automatic logic [32:0] alu_ref(input logic [ALU_OP_WIDTH-1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic c;
    logic [31:0] r;
    int sh;
    sh = b % 32;
    c = 1'b0;
    r = 32'd0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      ALU_AND: r = a & b;
      ALU_SRA: r = $signed(a) >>> sh;
      ALU_SRL: r = a >> sh;
      ALU_SLL: r = a << sh;
      ALU_LTS: c = $signed(a) < $signed(b);
      ALU_LTU: c = a < b;
      ALU_GES: c = $signed(a) >= $signed(b);
      ALU_GEU: c = a >= b;
      ALU_EQ:  c = a == b;
      ALU_NE:  c = a != b;
      default: r = 32'd0;
    endcase
    if (op >= ALU_LTS && op <= ALU_NE) r = {31'd0, c};
    return {c, r};
  endfunction

  // One clock cycle: drive at posedge+1, evaluate the model at negedge+1.
  task automatic step(input logic [1:0] v, input logic [1:0] rr);
    logic [1:0] elig;
    logic [1:0] g;
    bus.req_valid_i = v;
    bus.rsp_ready_i = rr;
    bus.req_op_i    = {op_v[1], op_v[0]};
    bus.req_a_i     = {a_v[1], a_v[0]};
    bus.req_b_i     = {b_v[1], b_v[0]};
    @(negedge clk_i);
    #1;
    for (int i = 0; i < 2; i++) elig[i] = v[i] && (!m_full[i] || rr[i]);
    if (elig == 2'b11)      g = (m_prio == 1) ? 2'b10 : 2'b01;
    else                    g = elig;
    last_ready = bus.req_ready_o;
    chk("req_ready", {62'd0, bus.req_ready_o}, {62'd0, g});
    chk("conflict_cnt", {48'd0, conflict_cnt}, m_cnt);
    if (elig == 2'b11 && m_cnt < 65535) m_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        if (i == 0) sb0.push_back(alu_ref(op_v[0], a_v[0], b_v[0]));
        else        sb1.push_back(alu_ref(op_v[1], a_v[1], b_v[1]));
        m_full[i] = 1'b1;
      end else if (rr[i]) begin
        m_full[i] = 1'b0;
      end
    end
    if (g == 2'b01) m_prio = 1;
    if (g == 2'b10) m_prio = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    m_full = 2'b00;
    m_prio = 0;
    m_cnt  = 0;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    bus.req_valid_i = 2'b00;
    @(posedge clk_i);
    #1;
    model_clear();
    arstn_i = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [ALU_OP_WIDTH-1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    op_v[i] = op;
    a_v[i]  = a;
    b_v[i]  = b;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a;
    a = $urandom;
    set_req(i, op_tab[$urandom_range(0, 13)], a,
            ($urandom_range(0, 3) == 0) ? a : $urandom);
  endtask

  // Monitor: pops the expected response on every response handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (arstn_i) begin
        chk("rsp_valid0", {63'd0, bus.rsp_valid_o[0]}, {63'd0, sb0.size() != 0});
        chk("rsp_valid1", {63'd0, bus.rsp_valid_o[1]}, {63'd0, sb1.size() != 0});
        if (bus.rsp_valid_o[0] && bus.rsp_ready_i[0]) begin
          if (sb0.size() == 0) chk("sb0_extra_rsp", 64'(sb0.size()), 64'd1);
          else begin
            e = sb0.pop_front();
            chk("rsp_result0", {32'd0, bus.rsp_result_o[31:0]}, {32'd0, e[31:0]});
            chk("rsp_cmp0", {63'd0, bus.rsp_cmp_o[0]}, {63'd0, e[32]});
          end
        end
        if (bus.rsp_valid_o[1] && bus.rsp_ready_i[1]) begin
          if (sb1.size() == 0) chk("sb1_extra_rsp", 64'(sb1.size()), 64'd1);
          else begin
            e = sb1.pop_front();
            chk("rsp_result1", {32'd0, bus.rsp_result_o[63:32]}, {32'd0, e[31:0]});
            chk("rsp_cmp1", {63'd0, bus.rsp_cmp_o[1]}, {63'd0, e[32]});
          end
        end
      end
    end
  end

  initial begin
    int g0;
    int g1;
    logic [1:0] pend;
    op_tab = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SRA, ALU_SRL,
               ALU_SLL, ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE};
    model_clear();
    set_req(0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, ALU_ADD, 32'd0, 32'd0);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    bus.req_op_i = '0;
    bus.req_a_i  = '0;
    bus.req_b_i  = '0;

    // Reset state, with valid requests that must be ignored.
    #12;
    chk("reset_rsp_valid", {62'd0, bus.rsp_valid_o}, 64'd0);
    chk("reset_result", bus.rsp_result_o, 64'd0);
    chk("reset_cmp", {62'd0, bus.rsp_cmp_o}, 64'd0);
    chk("reset_cnt", {48'd0, conflict_cnt}, 64'd0);
    chk("reset_req_ready", {62'd0, bus.req_ready_o}, 64'd0);
    do_reset();

    // Single issue on port 0.
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    step(2'b01, 2'b11);
    chk("single_valid", {62'd0, bus.rsp_valid_o}, 64'd1);
    chk("single_result", {32'd0, bus.rsp_result_o[31:0]}, 64'd12);
    step(2'b00, 2'b11);

    // Simultaneous requests after reset.
    do_reset();
    set_req(0, ALU_SUB, 32'd1, 32'd2);
    set_req(1, ALU_LTS, 32'hFFFFFFFF, 32'd1);
    step(2'b11, 2'b11);
    chk("simul_first", {62'd0, last_ready}, 64'd1);
    chk("simul_sub", {32'd0, bus.rsp_result_o[31:0]}, 64'hFFFFFFFF);
    step(2'b10, 2'b11);
    chk("simul_second", {62'd0, last_ready}, 64'd2);
    chk("simul_lts", {32'd0, bus.rsp_result_o[63:32]}, 64'd1);
    chk("simul_cmp", {63'd0, bus.rsp_cmp_o[1]}, 64'd1);
    chk("simul_cnt", {48'd0, conflict_cnt}, 64'd1);
    step(2'b00, 2'b11);

    // Sustained contention.
    do_reset();
    g0 = 0;
    g1 = 0;
    for (int k = 0; k < 10; k++) begin
      rand_req(0);
      rand_req(1);
      step(2'b11, 2'b11);
      g0 += int'(last_ready[0]);
      g1 += int'(last_ready[1]);
    end
    chk("contend_g0", 64'(g0), 64'd5);
    chk("contend_g1", 64'(g1), 64'd5);
    chk("contend_cnt", {48'd0, conflict_cnt}, 64'd10);
    step(2'b00, 2'b11);

    // Backpressure on port 0.
    do_reset();
    set_req(0, ALU_XOR, 32'hFFFFFFFF, 32'd1);
    step(2'b01, 2'b10);
    chk("bp_xor", {32'd0, bus.rsp_result_o[31:0]}, 64'hFFFFFFFE);
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    set_req(1, ALU_SLL, 32'd1, 32'd1);
    step(2'b11, 2'b10);
    chk("bp_blocked", {62'd0, last_ready}, 64'd2);
    chk("bp_sll", {32'd0, bus.rsp_result_o[63:32]}, 64'd2);
    chk("bp_hold", {32'd0, bus.rsp_result_o[31:0]}, 64'hFFFFFFFE);
    step(2'b01, 2'b11);
    chk("bp_release", {62'd0, last_ready}, 64'd1);
    step(2'b00, 2'b11);

    // Reset asserted between edges with both slots full.
    do_reset();
    rand_req(0);
    rand_req(1);
    step(2'b11, 2'b00);
    step(2'b11, 2'b00);
    #2;
    arstn_i = 1'b0;
    #1;
    chk("midrst_valid", {62'd0, bus.rsp_valid_o}, 64'd0);
    chk("midrst_ready", {62'd0, bus.req_ready_o}, 64'd0);
    model_clear();
    @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    step(2'b11, 2'b11);
    chk("midrst_first_grant", {62'd0, last_ready}, 64'd1);
    step(2'b00, 2'b11);

    // Randomized traffic; requests are held until accepted.
    do_reset();
    pend = 2'b00;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          rand_req(i);
          pend[i] = 1'b1;
        end
      end
      step(pend, 2'($urandom_range(0, 3)));
      pend = pend & ~last_ready;
    end
    step(2'b00, 2'b11);

    // Counter saturation.
    do_reset();
    for (int k = 0; k < 65540; k++) begin
      rand_req(0);
      rand_req(1);
      step(2'b11, 2'b11);
    end
    chk("sat_cnt", {48'd0, conflict_cnt}, 64'h0000_0000_0000_FFFF);
    step(2'b00, 2'b11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
